// File: rtl/booth_pkg.sv
// Shared constants and types for the radix-2 Booth sequential multiplier.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/booth_multiplier_if.sv
// Caller-side bus of the multiplier: start/operands in, product/busy out.
interface booth_multiplier_if
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   ab;
  logic                 busy;

  modport master (output start, a, b, input ab, busy);
  modport slave  (input start, a, b, output ab, busy);

endinterface

// File: rtl/booth_step.sv
// One combinational Booth iteration: conditional add/subtract of M, then
// arithmetic right shift of the {acc, Q, Q-1} register chain.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             qm1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] q_o,
  output logic             qm1_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    unique case ({q_i[0], qm1_i})
      2'b01:   sum = acc_i + m_i;
      2'b10:   sum = acc_i - m_i;
      default: sum = acc_i;
    endcase
    // The accumulator sign bit is replicated so the shift stays arithmetic.
    acc_o = {sum[WIDTH], sum[WIDTH:1]};
    q_o   = {sum[0], q_i[WIDTH-1:1]};
    qm1_o = q_i[0];
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed multiplier: one Booth step per clock, WIDTH steps per
// operation, product registered into ab only when the last step completes.
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  booth_multiplier_if.slave  bus
);

  localparam int CntW = $clog2(WIDTH + 1);

  state_e               state_q, state_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   ab_q, ab_d;

  logic [WIDTH:0]       stepAcc;
  logic [WIDTH-1:0]     stepQ;
  logic                 stepQm1;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .acc_o (stepAcc),
    .q_o   (stepQ),
    .qm1_o (stepQm1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      ab_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    ab_d    = ab_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          m_d     = {bus.a[WIDTH-1], bus.a};
          q_d     = bus.b;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = CntW'(WIDTH);
        end
      end
      RUN: begin
        acc_d = stepAcc;
        q_d   = stepQ;
        qm1_d = stepQm1;
        cnt_d = cnt_q - CntW'(1);
        // The acc MSB is only a guard bit; the product is the low 2*WIDTH bits.
        if (cnt_q == CntW'(1)) begin
          state_d = IDLE;
          ab_d    = {stepAcc[WIDTH-1:0], stepQ};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ab   = ab_q;
  assign bus.busy = (state_q == RUN);

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed and randomized scoreboard bench for booth_multiplier (WIDTH=8).
module tb_booth_multiplier;
  import booth_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  booth_multiplier_if #(.WIDTH(W)) bus ();

  booth_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;
  logic [2*W-1:0] expQ[$];

  function automatic logic [2*W-1:0] refProduct(input logic signed [W-1:0] x,
                                                input logic signed [W-1:0] y);
    logic signed [2*W-1:0] p;
    p = x * y;
    return p;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic startOnly(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y);
    expQ.push_back(refProduct(x, y));
    startOnly(x, y);
  endtask

  task automatic waitDone(input int expEdges);
    int edges;
    bit done;
    edges = 0;
    done  = 1'b0;
    while (!done) begin
      @(posedge clk);
      #1;
      edges++;
      if (!bus.busy) begin
        done = 1'b1;
      end else if (edges > 4 * W) begin
        testCount++;
        failCount++;
        $display("[TB] FAIL timeout: busy still %0b after %0d edges, required 0", bus.busy, edges);
        done = 1'b1;
      end
    end
    if (expEdges >= 0) checkValue("latency", 32'(edges), 32'(expEdges));
  endtask

  task automatic checkOutput(input string tag);
    logic [2*W-1:0] exp;
    if (expQ.size() == 0) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL %s: observed output with empty scoreboard, required an entry", tag);
    end else begin
      exp = expQ.pop_front();
      checkValue(tag, 32'(bus.ab), 32'(exp));
    end
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    applyStimulus(x, y);
    checkValue({tag, "_busyRise"}, 32'(bus.busy), 32'd1);
    waitDone(W);
    checkOutput(tag);
  endtask

  initial begin
    logic [W-1:0] nx, ny;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    checkValue("reset_ab", 32'(bus.ab), 32'd0);
    checkValue("reset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("9x9", 8'd9, 8'd9);
    runOp("m5x6", -8'sd5, 8'd6);
    runOp("12xm7", 8'd12, -8'sd7);
    runOp("m8xm8", -8'sd8, -8'sd8);
    runOp("m128xm128", 8'h80, 8'h80);
    runOp("m128x127", 8'h80, 8'd127);
    runOp("127x127", 8'd127, 8'd127);

    // Start during RUN and operand changes must not disturb the 9*9 job.
    applyStimulus(8'd9, 8'd9);
    repeat (2) @(posedge clk);
    #1;
    checkValue("holdPrev_ab", 32'(bus.ab), 32'(16'd16129));
    checkValue("holdPrev_busy", 32'(bus.busy), 32'd1);
    startOnly(8'd3, 8'd3);
    bus.a = 8'hFF;
    bus.b = 8'h55;
    checkValue("holdPrev_ab2", 32'(bus.ab), 32'(16'd16129));
    waitDone(-1);
    checkOutput("ignoreStart");
    @(posedge clk);
    #1;
    checkValue("idleHold_busy", 32'(bus.busy), 32'd0);
    checkValue("idleHold_ab", 32'(bus.ab), 32'(16'd81));

    runOp("0xm1", 8'd0, 8'hFF);

    // Asynchronous reset during the fourth step of 12*-7.
    startOnly(8'd12, -8'sd7);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("abort_ab", 32'(bus.ab), 32'd0);
    checkValue("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkValue("afterAbort_busy", 32'(bus.busy), 32'd0);
    checkValue("afterAbort_ab", 32'(bus.ab), 32'd0);
    runOp("m5x6_postReset", -8'sd5, 8'd6);

    for (int i = 0; i < 10; i++) begin
      runOp("rand", 8'($urandom), 8'($urandom));
    end

    // Back-to-back: start held high, next operands set while busy.
    nx = 8'($urandom);
    ny = 8'($urandom);
    applyStimulus(nx, ny);
    bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nx = 8'($urandom);
      ny = 8'($urandom);
      if (i < 7) begin
        bus.a = nx;
        bus.b = ny;
      end else begin
        bus.start = 1'b0;
      end
      waitDone(W);
      checkOutput("b2b");
      if (i < 7) begin
        expQ.push_back(refProduct(nx, ny));
        @(posedge clk);
        #1;
        checkValue("b2b_restart", 32'(bus.busy), 32'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Sequential signed multiplier using radix-2 Booth recoding.
- Takes two WIDTH-bit two's-complement operands on a one-cycle start pulse.
- Iterates one Booth step per clock and presents the 2*WIDTH-bit signed product.
- Sits as a small arithmetic co-processor block: the caller pulses start, waits for busy to fall, then reads ab.

Parameters:
- WIDTH, 8, operand width in bits (two's complement); product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk edge while idle.
- a  input  WIDTH  multiplicand, signed.
- b  input  WIDTH  multiplier, signed.
- ab  output  2*WIDTH  signed product, registered.
- busy  output  1  high while an operation is in progress.

Behaviour:
- Reset and clock: one clock (clk), reset is asynchronous and active-low (rst_n). While rst_n=0, ab=0, busy=0, state=IDLE, and all internal registers (accumulator, Q, Q-1, M, counter) are cleared.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts WIDTH steps.
- IDLE to RUN:
  - Occurs on a rising edge with start=1.
  - On that edge, capture M=a (sign-extended to WIDTH+1 bits) and Q=b.
  - Clear the accumulator (WIDTH+1 bits) and Q-1, and load counter=WIDTH.
  - busy rises on the same edge.
- RUN step (one per rising edge), using pair {Q[0],Q-1}:
  - 01: acc += M.
  - 10: acc -= M.
  - 00 or 11: no operation.
  - Then arithmetic-shift {acc,Q,Q-1} right by one, preserving the acc sign bit, and decrement the counter.
- RUN to IDLE:
  - On the edge that performs the WIDTH-th step, ab is loaded with the low 2*WIDTH bits of {acc,Q} after that shift, and busy falls.
- Latency:
  - The start edge plus WIDTH step edges gives WIDTH+1 rising edges in total (9 for WIDTH=8).
  - ab is valid and stable from the edge where busy falls.
- Accumulator width:
  - The accumulator is WIDTH+1 bits so that -2^(WIDTH-1) operands are correct.
  - The full signed range is exact, e.g. -128*-128=16384 and -128*127=-16256.
- ab holds the previous result, unchanged, throughout RUN; no partial products are visible. It holds indefinitely in IDLE.
- start while busy=1 is ignored; the operation in progress is unaffected.
- a and b are sampled only at the start edge; later changes have no effect.
- start held high continuously:
  - A new operation begins on the first edge in IDLE after completion.
  - That is, a back-to-back restart occurs one cycle after busy falls.
- Reset asserted mid-operation aborts immediately: ab=0 and busy=0. No result is produced until a fresh start.
- Zero operands need no special case; the product is 0.

Decomposition:
- Package booth_pkg:
  - WIDTH default constant.
  - State enum {IDLE, RUN}.
  - Counter width constant $clog2(WIDTH+1).
- Optional combinational sub-module booth_step:
  - Inputs: acc, Q, Q-1, M.
  - Performs the add/sub/none and the arithmetic right shift.
  - Outputs: next acc, Q, Q-1.
- The top level owns the FSM, counter, and the ab/busy registers.

Test Plan:
- Reset, then start with a=9, b=9 (1-cycle pulse) -> busy high for 9 edges, then ab=81 (0x0051), busy=0.
- a=-5, b=6 -> ab=-30 (0xFFE2); a=12, b=-7 -> ab=-84 (0xFFAC); a=-8, b=-8 -> ab=64.
- Boundary: a=-128, b=-128 -> 16384 (0x4000); a=-128, b=127 -> -16256 (0xC080); a=127, b=127 -> 16129; a=0, b=-1 -> 0.
- During RUN of 9*9: pulse start with a=3, b=3 and change a/b -> ignored, final ab=81; ab holds the prior result until busy falls.
- Assert rst_n=0 asynchronously at step 4 of 12*-7 -> ab=0 and busy=0 immediately; release reset, run -5*6 -> -30.
- Randomized signed pairs against a reference product, including back-to-back starts issued the cycle after busy falls.
